// File: rtl/clock_mon_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package clock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  localparam int CNT_W_DEF      = 10;
  localparam int EXP_PERIOD_DEF = 128;
  localparam int TOL_DEF        = 2;
  localparam int LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/phi0_clock_monitor_sync_edge.sv
// Three-flop synchronizer for an asynchronous clock-like input, with
// registered one-cycle rise/fall strobes. edge_rise is the unregistered
// rise condition so a consumer can act in the same cycle the strobe is set up.
module sync_edge (
  input  logic clkin,
  input  logic RST_n,
  input  logic din,
  output logic edge_rise,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  assign edge_rise = s2 & ~s3;

  // Synchronizer chain plus registered edge strobes.
  always_ff @(posedge clkin) begin
    if (!RST_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/phi0_clock_monitor.sv
// Divided-clock monitor: measures phiIn period in inClk cycles and flags lock
// once LOCK_COUNT consecutive periods fall inside EXP_PERIOD +/- TOL.
module phi0_clock_monitor
  import clock_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             inClk,
  input  logic             RST_n,
  input  logic             phiIn,
  output logic             phiRise,
  output logic             phiFall,
  output logic [CNT_W-1:0] period,
  output logic             periodValid,
  output logic             locked,
  output logic             lockErr
);

  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam int               MW   = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LCNT = MW'(LOCK_COUNT);
  localparam int               LO   = EXP_PERIOD - TOL;
  localparam int               HI   = EXP_PERIOD + TOL;

  mon_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] meas;
  logic [MW-1:0]    mcnt, mcnt_nxt;
  logic [CNT_W-1:0] per_nxt;
  logic             pv_nxt, err_nxt;
  logic             edge_rise, match, timeout;

  sync_edge u_sync (
    .clkin     (inClk),
    .RST_n     (RST_n),
    .din       (phiIn),
    .edge_rise (edge_rise),
    .rise      (phiRise),
    .fall      (phiFall)
  );

  // A saturated counter reports MAX, which can never count as a match even
  // if the tolerance window were to reach it.
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign meas    = (cnt == MAX) ? MAX : cnt_inc[CNT_W-1:0];
  assign match   = (int'(meas) >= LO) && (int'(meas) <= HI) && (meas != MAX);
  // A rise in the saturating cycle wins over the timeout.
  assign timeout = (cnt == MAX) && !edge_rise;

  // Period counter: restarts on each synchronized rise, saturates at MAX.
  always_ff @(posedge inClk) begin
    if (!RST_n)         cnt <= '0;
    else if (edge_rise) cnt <= '0;
    else if (cnt != MAX) cnt <= cnt_inc[CNT_W-1:0];
  end

  // Next-state and next-output decode for the lock FSM.
  always_comb begin
    state_nxt = state;
    mcnt_nxt  = mcnt;
    per_nxt   = period;
    pv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (edge_rise) begin
          state_nxt = MEASURE;
          mcnt_nxt  = '0;
        end
      end
      MEASURE: begin
        if (edge_rise) begin
          pv_nxt  = 1'b1;
          per_nxt = meas;
          if (!match) begin
            mcnt_nxt = '0;
          end else if (mcnt == LCNT - 1'b1) begin
            mcnt_nxt  = LCNT;
            state_nxt = LOCKED;
          end else begin
            mcnt_nxt = mcnt + 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          mcnt_nxt  = '0;
        end
      end
      LOCKED: begin
        if (edge_rise) begin
          pv_nxt  = 1'b1;
          per_nxt = meas;
          if (!match) begin
            state_nxt = MEASURE;
            mcnt_nxt  = '0;
            err_nxt   = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
          mcnt_nxt  = '0;
          err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        mcnt_nxt  = '0;
      end
    endcase
  end

  // State and registered outputs; locked tracks the state being entered.
  always_ff @(posedge inClk) begin
    if (!RST_n) begin
      state       <= IDLE;
      mcnt        <= '0;
      period      <= '0;
      periodValid <= 1'b0;
      locked      <= 1'b0;
      lockErr     <= 1'b0;
    end else begin
      state       <= state_nxt;
      mcnt        <= mcnt_nxt;
      period      <= per_nxt;
      periodValid <= pv_nxt;
      locked      <= (state_nxt == LOCKED);
      lockErr     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_phi0_clock_monitor.sv
// Directed bench for phi0_clock_monitor: lock, tolerance, timeout, edge
// latency, reset while locked and the saturation race.
module tb_phi0_clock_monitor;

  logic       inClk = 1'b0;
  logic       RST_n = 1'b0;
  logic       phiIn = 1'b0;
  logic       phiRise, phiFall, periodValid, locked, lockErr;
  logic [9:0] period;

  int n_run  = 0;
  int n_fail = 0;
  int pv_cnt = 0;
  int err_cnt = 0;
  int long_strobe = 0;
  logic prev_rise = 1'b0, prev_fall = 1'b0, prev_pv = 1'b0, prev_err = 1'b0;

  phi0_clock_monitor dut (
    .inClk       (inClk),
    .RST_n       (RST_n),
    .phiIn       (phiIn),
    .phiRise     (phiRise),
    .phiFall     (phiFall),
    .period      (period),
    .periodValid (periodValid),
    .locked      (locked),
    .lockErr     (lockErr)
  );

  always #5 inClk = ~inClk;

  // Event monitor sampled just after each active edge.
  always @(posedge inClk) begin
    #1;
    if (periodValid) pv_cnt++;
    if (lockErr) err_cnt++;
    if ((phiRise && prev_rise) || (phiFall && prev_fall) ||
        (periodValid && prev_pv) || (lockErr && prev_err)) long_strobe++;
    prev_rise = phiRise;
    prev_fall = phiFall;
    prev_pv   = periodValid;
    prev_err  = lockErr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One phiIn period of len inClk cycles, starting with the rising edge.
  task automatic wave(input int len);
    phiIn = 1'b1;
    repeat (len / 2) @(negedge inClk);
    phiIn = 1'b0;
    repeat (len - len / 2) @(negedge inClk);
  endtask

  task automatic waves(input int n, input int len);
    for (int i = 0; i < n; i++) wave(len);
  endtask

  function automatic logic [31:0] outs();
    return {17'b0, phiRise, phiFall, period, periodValid, locked, lockErr};
  endfunction

  initial begin
    // Reset state
    RST_n = 1'b0;
    phiIn = 1'b0;
    repeat (3) @(negedge inClk);
    chk("reset_outs", outs(), 32'd0);
    RST_n = 1'b1;
    @(negedge inClk);

    // Edge latency: phiIn first sampled high at edge k
    phiIn = 1'b1;
    @(posedge inClk); #1; chk("rise_k",   32'(phiRise), 32'd0);
    @(posedge inClk); #1; chk("rise_k1",  32'(phiRise), 32'd0);
    @(posedge inClk); #1; chk("rise_k2",  32'(phiRise), 32'd1);
    @(posedge inClk); #1; chk("rise_k3",  32'(phiRise), 32'd0);
    @(negedge inClk);
    phiIn = 1'b0;
    @(posedge inClk); #1; chk("fall_k",   32'(phiFall), 32'd0);
    @(posedge inClk); #1; chk("fall_k1",  32'(phiFall), 32'd0);
    @(posedge inClk); #1; chk("fall_k2",  32'(phiFall), 32'd1);
    @(posedge inClk); #1; chk("fall_k3",  32'(phiFall), 32'd0);
    chk("edge_no_pv", 32'(pv_cnt), 32'd0);

    // Fresh start for the lock sequence
    @(negedge inClk);
    RST_n = 1'b0;
    repeat (2) @(negedge inClk);
    chk("reset2_outs", outs(), 32'd0);
    RST_n = 1'b1;
    repeat (4) @(negedge inClk);

    // Lock: rises 1..4 not yet locked, rise 5 locks
    waves(4, 128);
    chk("lock_pre_locked", 32'(locked), 32'd0);
    chk("lock_pre_pv", 32'(pv_cnt), 32'd3);
    wave(128);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_pv", 32'(pv_cnt), 32'd4);
    chk("lock_period", 32'(period), 32'd128);
    chk("lock_no_err", 32'(err_cnt), 32'd0);

    // Tolerance: 130 accepted, 131 drops lock, relock after 4 good periods
    wave(130);
    wave(131);
    chk("tol130_period", 32'(period), 32'd130);
    chk("tol130_locked", 32'(locked), 32'd1);
    chk("tol130_err", 32'(err_cnt), 32'd0);
    wave(128);
    chk("tol131_period", 32'(period), 32'd131);
    chk("tol131_locked", 32'(locked), 32'd0);
    chk("tol131_err", 32'(err_cnt), 32'd1);
    waves(3, 128);
    chk("relock_pre", 32'(locked), 32'd0);
    wave(128);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_pv", 32'(pv_cnt), 32'd11);

    // Stopped clock: timeout drops to IDLE with one lockErr, no periodValid
    repeat (1100) @(negedge inClk);
    chk("stop_locked", 32'(locked), 32'd0);
    chk("stop_err", 32'(err_cnt), 32'd2);
    chk("stop_pv", 32'(pv_cnt), 32'd11);
    wave(128);
    chk("stop_first_rise_pv", 32'(pv_cnt), 32'd11);
    waves(3, 128);
    chk("stop_relock_pre", 32'(locked), 32'd0);
    wave(128);
    chk("stop_relock", 32'(locked), 32'd1);
    chk("stop_relock_pv", 32'(pv_cnt), 32'd15);

    // Reset for one cycle while locked
    RST_n = 1'b0;
    @(posedge inClk); #1;
    chk("rstlock_outs", outs(), 32'd0);
    @(negedge inClk);
    RST_n = 1'b1;
    chk("rstlock_err", 32'(err_cnt), 32'd2);
    @(negedge inClk);
    waves(4, 128);
    chk("rstlock_pre", 32'(locked), 32'd0);
    chk("rstlock_pre_pv", 32'(pv_cnt), 32'd18);
    wave(128);
    chk("rstlock_relock", 32'(locked), 32'd1);

    // Saturation race: a 1024-cycle period lands its rise on cnt==MAX
    wave(1024);
    chk("sat_pre_locked", 32'(locked), 32'd1);
    wave(128);
    chk("sat_period", 32'(period), 32'd1023);
    chk("sat_locked", 32'(locked), 32'd0);
    chk("sat_err", 32'(err_cnt), 32'd3);
    chk("sat_pv", 32'(pv_cnt), 32'd21);
    wave(128);
    chk("sat_measure_pv", 32'(pv_cnt), 32'd22);
    chk("sat_measure_period", 32'(period), 32'd128);

    chk("strobe_width", 32'(long_strobe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
